// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cipher_pkg
// Description : Shared definitions for the cipher blocks. Holds the 5x5
//               letter/code grid (keyword DANIEL, J omitted), the decrypt
//               FSM state type and the letter-to-code helper function.
//               Grid, codes are row*10 + column:
//                 row 1: D A N I E    row 2: L B C F G    row 3: H K M O P
//                 row 4: Q R S T U    row 5: V W X Y Z
// Revision    : 1.0 - initial release
// ============================================================================
package cipher_pkg;

  localparam int         CODE_ROWS      = 5;
  localparam int         CODE_COLS      = 5;
  localparam logic [7:0] INVALID_LETTER = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Letter to row/column code; any character off the grid gives code 0
  function automatic logic [7:0] letter_to_code(input logic [7:0] letter);
    logic [7:0] code;
    case (letter)
      "D": code = 8'd11;  "A": code = 8'd12;  "N": code = 8'd13;
      "I": code = 8'd14;  "E": code = 8'd15;
      "L": code = 8'd21;  "B": code = 8'd22;  "C": code = 8'd23;
      "F": code = 8'd24;  "G": code = 8'd25;
      "H": code = 8'd31;  "K": code = 8'd32;  "M": code = 8'd33;
      "O": code = 8'd34;  "P": code = 8'd35;
      "Q": code = 8'd41;  "R": code = 8'd42;  "S": code = 8'd43;
      "T": code = 8'd44;  "U": code = 8'd45;
      "V": code = 8'd51;  "W": code = 8'd52;  "X": code = 8'd53;
      "Y": code = 8'd54;  "Z": code = 8'd55;
      default: code = 8'd0;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cipher_code_to_letter.sv
`default_nettype none
// ============================================================================
// Module      : cipher_code_to_letter
// Description : Combinational lookup from a row/column code back to its
//               uppercase ASCII letter. Codes off the 5x5 grid give '?'.
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_code_to_letter
  import cipher_pkg::*;
(
  input  logic [7:0] code_i,
  output logic [7:0] letter_o
);

  // Grid lookup; default covers every code outside rows/columns 1-5
  always_comb begin
    letter_o = INVALID_LETTER;
    case (code_i)
      8'd11: letter_o = "D";  8'd12: letter_o = "A";  8'd13: letter_o = "N";
      8'd14: letter_o = "I";  8'd15: letter_o = "E";
      8'd21: letter_o = "L";  8'd22: letter_o = "B";  8'd23: letter_o = "C";
      8'd24: letter_o = "F";  8'd25: letter_o = "G";
      8'd31: letter_o = "H";  8'd32: letter_o = "K";  8'd33: letter_o = "M";
      8'd34: letter_o = "O";  8'd35: letter_o = "P";
      8'd41: letter_o = "Q";  8'd42: letter_o = "R";  8'd43: letter_o = "S";
      8'd44: letter_o = "T";  8'd45: letter_o = "U";
      8'd51: letter_o = "V";  8'd52: letter_o = "W";  8'd53: letter_o = "X";
      8'd54: letter_o = "Y";  8'd55: letter_o = "Z";
      default: letter_o = INVALID_LETTER;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decrypt_stream.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_stream
// Description : Streaming decryptor. On start the ASCII secret is latched and
//               converted, one character per cycle, into key codes. Each
//               accepted cipher byte has the cycling key code subtracted and
//               the result mapped back to a letter, registered one cycle
//               after acceptance, with valid/ready flow control on both
//               sides.
//               Optional build macro DECRYPT_STRICT_EN: range-check every
//               code (borrow or off-grid gives '?' and sets sticky o_r_error).
//               Without it o_r_error is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module decrypt_stream
  import cipher_pkg::*;
#(
  parameter int p_message_length = 27,
  parameter int p_secret_length  = 6
) (
  input  logic                         i_w_clk,
  input  logic                         i_w_rst_n,
  input  logic                         i_w_start,
  input  logic [p_secret_length*8-1:0] i_w_secret,
  input  logic [7:0]                   i_w_cipher_byte,
  input  logic                         i_w_cipher_valid,
  output logic                         o_w_cipher_ready,
  output logic [7:0]                   o_r_text,
  output logic                         o_r_text_valid,
  input  logic                         i_w_text_ready,
  output logic                         o_r_busy,
  output logic                         o_r_done,
  output logic                         o_r_error
);

  localparam int SW = p_secret_length * 8;
  localparam int KW = (p_secret_length > 1) ? $clog2(p_secret_length) : 1;
  localparam int CW = (p_message_length > 1) ? $clog2(p_message_length) : 1;
  localparam logic [KW-1:0] c_key_last  = KW'(p_secret_length - 1);
  localparam logic [CW-1:0] c_byte_last = CW'(p_message_length - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   secret_q;
  logic [7:0]      key_q [p_secret_length];
  logic [KW-1:0]   load_cnt_q;
  logic [KW-1:0]   key_idx_q;
  logic [CW-1:0]   byte_cnt_q;
  logic [7:0]      text_q;
  logic            text_valid_q;
  logic            done_q;
  logic            error_q;

  logic            w_start;
  logic            w_accept;
  logic            w_consume;
  logic [7:0]      w_key;
  logic [7:0]      w_diff;
  logic [7:0]      w_lut_letter;
  logic [7:0]      w_letter;
  logic            w_bad;

  assign w_start          = (state_q == ST_IDLE) && i_w_start;
  assign o_w_cipher_ready = (state_q == ST_RUN) && (!text_valid_q || i_w_text_ready);
  assign w_accept         = i_w_cipher_valid && o_w_cipher_ready;
  assign w_consume        = text_valid_q && i_w_text_ready;

  assign w_key  = key_q[key_idx_q];
  assign w_diff = i_w_cipher_byte - w_key;

  cipher_code_to_letter u_lut (
    .code_i   (w_diff),
    .letter_o (w_lut_letter)
  );

`ifdef DECRYPT_STRICT_EN
  logic w_borrow;
  assign w_borrow = (i_w_cipher_byte < w_key);
  assign w_bad    = w_borrow || (w_lut_letter == INVALID_LETTER);
  assign w_letter = w_bad ? INVALID_LETTER : w_lut_letter;
`else
  assign w_bad    = 1'b0;
  assign w_letter = w_lut_letter;
`endif

  // State register
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic: load keys, stream the message, drain the last letter
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_w_start) state_d = ST_LOAD;
      ST_LOAD:  if (load_cnt_q == c_key_last) state_d = ST_RUN;
      ST_RUN:   if (w_accept && (byte_cnt_q == c_byte_last)) state_d = ST_FLUSH;
      ST_FLUSH: if (w_consume) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Secret latch and per-cycle conversion of its characters into key codes
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      secret_q   <= '0;
      load_cnt_q <= '0;
      for (int i = 0; i < p_secret_length; i++) key_q[i] <= 8'd0;
    end else if (w_start) begin
      secret_q   <= i_w_secret;
      load_cnt_q <= '0;
    end else if (state_q == ST_LOAD) begin
      key_q[load_cnt_q] <= letter_to_code(secret_q[SW-1 -: 8]);
      secret_q          <= secret_q << 8;
      load_cnt_q        <= load_cnt_q + 1'b1;
    end
  end

  // Byte counter and key index, both advancing on each accepted byte
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      byte_cnt_q <= '0;
      key_idx_q  <= '0;
    end else if (w_start) begin
      byte_cnt_q <= '0;
      key_idx_q  <= '0;
    end else if (w_accept) begin
      byte_cnt_q <= byte_cnt_q + 1'b1;
      key_idx_q  <= (key_idx_q == c_key_last) ? '0 : key_idx_q + 1'b1;
    end
  end

  // Output letter register; a new letter takes priority over consumption
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      text_q       <= 8'h00;
      text_valid_q <= 1'b0;
    end else if (w_accept) begin
      text_q       <= w_letter;
      text_valid_q <= 1'b1;
    end else if (w_consume) begin
      text_valid_q <= 1'b0;
    end
  end

  // Done pulse on the final drain and sticky error flag cleared by start
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FLUSH) && w_consume;
      if (w_start)               error_q <= 1'b0;
      else if (w_accept && w_bad) error_q <= 1'b1;
    end
  end

  assign o_r_text       = text_q;
  assign o_r_text_valid = text_valid_q;
  assign o_r_busy       = (state_q != ST_IDLE);
  assign o_r_done       = done_q;
  assign o_r_error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_decrypt_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_decrypt_stream
// Description : Scoreboard testbench for decrypt_stream. A behavioural grid
//               model predicts each letter when a byte is accepted; a monitor
//               pops and compares on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decrypt_stream;

  localparam int MSG = 27;
  localparam int SEC = 6;
`ifdef DECRYPT_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [SEC*8-1:0] secret = '0;
  logic [7:0]     cbyte = 8'h00;
  logic           cvalid = 1'b0;
  logic           cready;
  logic [7:0]     text;
  logic           text_valid;
  logic           text_ready = 1'b1;
  logic           busy, done, error;

  decrypt_stream #(.p_message_length(MSG), .p_secret_length(SEC)) dut (
    .i_w_clk          (clk),
    .i_w_rst_n        (rst_n),
    .i_w_start        (start),
    .i_w_secret       (secret),
    .i_w_cipher_byte  (cbyte),
    .i_w_cipher_valid (cvalid),
    .o_w_cipher_ready (cready),
    .o_r_text         (text),
    .o_r_text_valid   (text_valid),
    .i_w_text_ready   (text_ready),
    .o_r_busy         (busy),
    .o_r_done         (done),
    .o_r_error        (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;
  int rmode = 0;
  bit stalled = 1'b0;
  int stall_left = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ciph [MSG];
  string TBL = "DANIELBCFGHKMOPQRSTUVWXYZ";

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: grid position i encodes as (i/5+1)*10 + (i%5+1)
  function automatic int code_of(input logic [7:0] ch);
    for (int i = 0; i < 25; i++)
      if (8'(TBL[i]) == ch) return (i / 5 + 1) * 10 + (i % 5) + 1;
    return 0;
  endfunction

  function automatic logic [7:0] decode(input int d);
    int r, c;
    if (d < 0) return 8'h3F;
    r = d / 10;
    c = d % 10;
    if (r >= 1 && r <= 5 && c >= 1 && c <= 5) return 8'(TBL[(r - 1) * 5 + c - 1]);
    return 8'h3F;
  endfunction

  function automatic int key_at(input logic [SEC*8-1:0] sec, input int i);
    return code_of(sec[(SEC - 1 - (i % SEC)) * 8 +: 8]);
  endfunction

  task automatic build_msg(input logic [SEC*8-1:0] sec, input string pt);
    for (int i = 0; i < MSG; i++) ciph[i] = 8'(code_of(8'(pt[i])) + key_at(sec, i));
  endtask

  task automatic build_random(input logic [SEC*8-1:0] sec);
    for (int i = 0; i < MSG; i++) begin
      if ($urandom_range(0, 7) == 0) ciph[i] = 8'($urandom_range(0, 255));
      else ciph[i] = 8'(code_of(8'(TBL[$urandom_range(0, 24)])) + key_at(sec, i));
    end
  endtask

  function automatic logic [SEC*8-1:0] random_secret();
    logic [SEC*8-1:0] s;
    string odd = "J#a ";
    for (int i = 0; i < SEC; i++) begin
      if ($urandom_range(0, 5) == 0) s[i*8 +: 8] = 8'(odd[$urandom_range(0, 3)]);
      else s[i*8 +: 8] = 8'(TBL[$urandom_range(0, 24)]);
    end
    return s;
  endfunction

  // Downstream ready: always high, random, or a 3-cycle stall on first 'E'
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0: text_ready = 1'b1;
      1: text_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (stall_left > 0) begin
          text_ready = 1'b0;
          stall_left--;
        end else if (!stalled && text_valid && text == 8'h45) begin
          stalled = 1'b1;
          stall_left = 2;
          text_ready = 1'b0;
        end else begin
          text_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: scoreboard pops on handshakes plus latency/hold/backpressure checks
  initial begin
    bit prev_acc = 1'b0;
    bit prev_hold = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_acc = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (prev_acc) begin
          check("latency_valid", int'(text_valid), 1);
          if (exp_q.size() > 0) check("latency_letter", int'(text), int'(exp_q[$]));
          else begin checks++; fails++; $display("FAIL latency_letter: got 0x%0h, expected a pending letter", text); end
        end
        if (prev_hold) begin
          check("hold_text", int'(text), int'(held));
          check("hold_valid", int'(text_valid), 1);
        end
        if (text_valid && !text_ready) check("backpressure_ready", int'(cready), 0);
        if (done) done_cnt++;
        if (text_valid && text_ready) begin
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL letter: got 0x%0h, expected no output", text);
          end else begin
            e = exp_q.pop_front();
            check("letter", int'(text), int'(e));
          end
        end
        prev_acc = cvalid && cready;
        prev_hold = text_valid && !text_ready;
        held = text;
      end
    end
  end

  task automatic send_byte(input logic [7:0] c, input logic [7:0] e);
    int n = 0;
    bit acc;
    cbyte = c;
    cvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = cready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++; fails++;
      $display("FAIL accept_timeout: got no acceptance, expected one within 200 cycles");
    end else begin
      exp_q.push_back(e);
    end
    cvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_text"}, int'(text), 0);
    check({tag, "_valid"}, int'(text_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_cready"}, int'(cready), 0);
  endtask

  // One message: start, LOAD checks, stream with model predictions, end checks
  task automatic run_msg(input logic [SEC*8-1:0] sec, input bit start_mid, input int reset_at, input bit gaps);
    int n, d0;
    bit any_bad = 1'b0;
    int dv;
    n = 0;
    while (busy && n < 500) begin @(posedge clk); #1; n++; end
    if (busy) begin checks++; fails++; $display("FAIL idle_wait: got busy=1, expected 0"); end
    stalled = 1'b0;
    d0 = done_cnt;
    secret = sec;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    secret = {$urandom, $urandom};
    for (int i = 0; i < SEC; i++) begin
      @(negedge clk);
      check("load_cready", int'(cready), 0);
      check("load_busy", int'(busy), 1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < MSG; i++) begin
      if (i == reset_at) begin
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("noauto_start_busy", int'(busy), 0);
        return;
      end
      if (start_mid && i == 10) begin
        start = 1'b1;
        secret = {$urandom, $urandom};
      end
      dv = int'(ciph[i]) - key_at(sec, i);
      if (decode(dv) == 8'h3F) any_bad = 1'b1;
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send_byte(ciph[i], decode(dv));
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 300) begin @(posedge clk); #2; n++; end
    if (done_cnt == d0) begin checks++; fails++; $display("FAIL done_timeout: got no done pulse, expected one"); end
    repeat (3) @(posedge clk);
    #2;
    check("done_once", done_cnt - d0, 1);
    check("done_low", int'(done), 0);
    check("busy_end", int'(busy), 0);
    check("error_end", int'(error), STRICT ? int'(any_bad) : 0);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [SEC*8-1:0] s;
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SEC*8-1:0] sec;
    string pt = "TEXTFOARTELUNGDEMULTELITERE";
    sec = "DANILA";
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", int'(busy), 0);

    // Known stream, ready held high
    rmode = 0;
    build_msg(sec, pt);
    run_msg(sec, 1'b0, -1, 1'b0);

    // Three-cycle downstream stall after the 'E'
    rmode = 2;
    run_msg(sec, 1'b0, -1, 1'b0);

    // Borrowing code: cipher 5 with key 'D'
    rmode = 1;
    build_msg(sec, pt);
    ciph[0] = 8'd5;
    run_msg(sec, 1'b0, -1, 1'b0);

    // Clean message afterwards: error cleared by the new start
    rmode = 0;
    build_msg(sec, pt);
    run_msg(sec, 1'b0, -1, 1'b0);

    // Start pulse during RUN is ignored
    rmode = 1;
    run_msg(sec, 1'b1, -1, 1'b1);

    // Reset after ten bytes, then a full stream decodes normally
    run_msg(sec, 1'b0, 10, 1'b0);
    rmode = 0;
    run_msg(sec, 1'b0, -1, 1'b0);

    // Random secrets and streams
    rmode = 1;
    for (int m = 0; m < 6; m++) begin
      sec = random_secret();
      build_random(sec);
      run_msg(sec, 1'b0, -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
